// File: rtl/gpio_pkg.sv
// Shared definitions for the GPIO bank: register map, address decode constants, reset values.
// Optional input debounce is enabled by defining GPIO_DEBOUNCE_EN.
package gpio_pkg;

  localparam int ADR_LSB   = 2;
  localparam int REG_SEL_W = 3;

  typedef enum logic [REG_SEL_W-1:0] {
    REG_IN      = 3'd0,
    REG_OUT     = 3'd1,
    REG_DIR     = 3'd2,
    REG_RISE_EN = 3'd3,
    REG_FALL_EN = 3'd4,
    REG_PEND    = 3'd5
  } reg_e;

  localparam logic [31:0] REG_RST = 32'h0000_0000;

endpackage

// File: rtl/gpio_in_filter.sv
// One GPIO input pin: two-flop synchroniser, optional debounce (GPIO_DEBOUNCE_EN), edge detect.
// value_o is the filtered level; rise_o/fall_o pulse for one cycle when it changes.
module gpio_in_filter #(
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic pad_i,
  output logic value_o,
  output logic rise_o,
  output logic fall_o
);

  logic sync1_q, sync2_q, prev_q;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      prev_q  <= 1'b0;
    end else begin
      sync1_q <= pad_i;
      sync2_q <= sync1_q;
      prev_q  <= value_o;
    end
  end

`ifdef GPIO_DEBOUNCE_EN
  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             filt_q, filt_d;

  always_comb begin
    cnt_d  = '0;
    filt_d = filt_q;
    if (sync2_q != filt_q) begin
      if (cnt_q == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
        filt_d = sync2_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q  <= '0;
      filt_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      filt_q <= filt_d;
    end
  end

  assign value_o = filt_q;
`else
  assign value_o = sync2_q;
`endif

  assign rise_o = value_o & ~prev_q;
  assign fall_o = ~value_o & prev_q;

endmodule

// File: rtl/gpio_bank.sv
// Wishbone GPIO bank: direction/output registers, synchronised inputs, edge-capture PEND with irq.
// Define GPIO_DEBOUNCE_EN to insert a DEBOUNCE_CYCLES filter on every input.
module gpio_bank
  import gpio_pkg::*;
#(
  parameter int WIDTH           = 8,
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wb_cyc_i,
  input  logic             wb_stb_i,
  input  logic             wb_we_i,
  input  logic [31:0]      wb_adr_i,
  input  logic [31:0]      wb_dat_i,
  output logic [31:0]      wb_dat_o,
  output logic             wb_ack_o,
  input  logic [WIDTH-1:0] gpio_i,
  output logic [WIDTH-1:0] gpio_o,
  output logic [WIDTH-1:0] gpio_oe,
  output logic             irq
);

  logic [WIDTH-1:0] in_val, rise, fall;

  for (genvar g = 0; g < WIDTH; g++) begin : g_pin
    gpio_in_filter #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_filter (
      .clk    (clk),
      .rst    (rst),
      .pad_i  (gpio_i[g]),
      .value_o(in_val[g]),
      .rise_o (rise[g]),
      .fall_o (fall[g])
    );
  end

  logic [WIDTH-1:0] out_q, out_d;
  logic [WIDTH-1:0] dir_q, dir_d;
  logic [WIDTH-1:0] rise_en_q, rise_en_d;
  logic [WIDTH-1:0] fall_en_q, fall_en_d;
  logic [WIDTH-1:0] pend_q, pend_d;
  logic [31:0]      dat_q, dat_d;
  logic             ack_q, ack_d;
  logic             irq_q, irq_d;

  logic                 req, wr;
  logic [REG_SEL_W-1:0] reg_sel;
  logic [WIDTH-1:0]     wdata, w1c, set;
  logic [31:0]          rdata;

  // Address bits outside adr[4:2] and data bits above WIDTH are intentionally ignored.
  logic unused_bus;
  assign unused_bus = ^{wb_adr_i, wb_dat_i};

  always_comb begin
    req     = wb_cyc_i & wb_stb_i & ~ack_q;
    wr      = req & wb_we_i;
    reg_sel = wb_adr_i[ADR_LSB +: REG_SEL_W];
    wdata   = wb_dat_i[WIDTH-1:0];

    out_d     = out_q;
    dir_d     = dir_q;
    rise_en_d = rise_en_q;
    fall_en_d = fall_en_q;
    w1c       = '0;
    if (wr) begin
      case (reg_sel)
        REG_OUT:     out_d     = wdata;
        REG_DIR:     dir_d     = wdata;
        REG_RISE_EN: rise_en_d = wdata;
        REG_FALL_EN: fall_en_d = wdata;
        REG_PEND:    w1c       = wdata;
        default:     ;
      endcase
    end

    // Set is OR'd after the clear so a same-cycle edge beats a W1C write.
    set    = ((rise & rise_en_q) | (fall & fall_en_q)) & ~dir_q;
    pend_d = (pend_q & ~w1c) | set;

    rdata = '0;
    case (reg_sel)
      REG_IN:      rdata[WIDTH-1:0] = in_val;
      REG_OUT:     rdata[WIDTH-1:0] = out_q;
      REG_DIR:     rdata[WIDTH-1:0] = dir_q;
      REG_RISE_EN: rdata[WIDTH-1:0] = rise_en_q;
      REG_FALL_EN: rdata[WIDTH-1:0] = fall_en_q;
      REG_PEND:    rdata[WIDTH-1:0] = pend_q;
      default:     ;
    endcase

    ack_d = req;
    dat_d = (req & ~wb_we_i) ? rdata : '0;
    irq_d = |(pend_q & (rise_en_q | fall_en_q));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_q     <= REG_RST[WIDTH-1:0];
      dir_q     <= REG_RST[WIDTH-1:0];
      rise_en_q <= REG_RST[WIDTH-1:0];
      fall_en_q <= REG_RST[WIDTH-1:0];
      pend_q    <= REG_RST[WIDTH-1:0];
      dat_q     <= REG_RST;
      ack_q     <= 1'b0;
      irq_q     <= 1'b0;
    end else begin
      out_q     <= out_d;
      dir_q     <= dir_d;
      rise_en_q <= rise_en_d;
      fall_en_q <= fall_en_d;
      pend_q    <= pend_d;
      dat_q     <= dat_d;
      ack_q     <= ack_d;
      irq_q     <= irq_d;
    end
  end

  assign wb_dat_o = dat_q;
  assign wb_ack_o = ack_q;
  assign gpio_o   = out_q;
  assign gpio_oe  = dir_q;
  assign irq      = irq_q;

endmodule

// File: tb/tb_gpio_bank.sv
// Directed bench for gpio_bank: expected bus read data is queued at issue and popped on ack.
// Inputs are driven and outputs sampled on the falling clock edge.
module tb_gpio_bank;

  logic        clk = 1'b0;
  logic        rst;
  logic        wb_cyc_i, wb_stb_i, wb_we_i;
  logic [31:0] wb_adr_i, wb_dat_i, wb_dat_o;
  logic        wb_ack_o;
  logic [7:0]  gpio_i, gpio_o, gpio_oe;
  logic        irq;

  gpio_bank #(.WIDTH(8), .DEBOUNCE_CYCLES(16)) dut (
    .clk     (clk),
    .rst     (rst),
    .wb_cyc_i(wb_cyc_i),
    .wb_stb_i(wb_stb_i),
    .wb_we_i (wb_we_i),
    .wb_adr_i(wb_adr_i),
    .wb_dat_i(wb_dat_i),
    .wb_dat_o(wb_dat_o),
    .wb_ack_o(wb_ack_o),
    .gpio_i  (gpio_i),
    .gpio_o  (gpio_o),
    .gpio_oe (gpio_oe),
    .irq     (irq)
  );

  always #5 clk = ~clk;

`ifdef GPIO_DEBOUNCE_EN
  localparam int LAT = 2 + 16;
`else
  localparam int LAT = 2;
`endif

  localparam logic [31:0] A_IN = 32'h00, A_OUT = 32'h04, A_DIR = 32'h08,
                          A_REN = 32'h0C, A_FEN = 32'h10, A_PEND = 32'h14,
                          A_R6 = 32'h18, A_R7 = 32'h1C;

  int          checks   = 0;
  int          failures = 0;
  logic [31:0] exp_q[$];
  string       tag_q[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic wait_ack(input string tag);
    bit seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      seen = (wb_ack_o === 1'b1);
    end
    check({tag, "_ack"}, 32'(wb_ack_o), 32'd1);
  endtask

  task automatic bus_write(input logic [31:0] adr, input logic [31:0] dat);
    @(negedge clk);
    wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = 1'b1;
    wb_adr_i = adr;  wb_dat_i = dat;
    wait_ack($sformatf("wr%02h", adr));
    wb_cyc_i = 1'b0; wb_stb_i = 1'b0; wb_we_i = 1'b0;
  endtask

  task automatic bus_read(input logic [31:0] adr, input logic [31:0] exp, input string tag);
    logic [31:0] e;
    string       t;
    exp_q.push_back(exp);
    tag_q.push_back(tag);
    @(negedge clk);
    wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = 1'b0;
    wb_adr_i = adr;  wb_dat_i = '0;
    wait_ack(tag);
    e = exp_q.pop_front();
    t = tag_q.pop_front();
    if (wb_ack_o === 1'b1) check(t, wb_dat_o, e);
    wb_cyc_i = 1'b0; wb_stb_i = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    wb_cyc_i = 1'b0; wb_stb_i = 1'b0; wb_we_i = 1'b0;
    wb_adr_i = '0;   wb_dat_i = '0;   gpio_i = '0;
    repeat (4) @(negedge clk);
    check("rst_ack", 32'(wb_ack_o), 32'd0);
    check("rst_dat", wb_dat_o, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // Reset state of every register and output
    for (int r = 0; r < 8; r++) bus_read(32'(r) << 2, 32'd0, $sformatf("rst_reg%0d", r));
    check("rst_oe", 32'(gpio_oe), 32'd0);
    check("rst_o", 32'(gpio_o), 32'd0);
    check("rst_irq", 32'(irq), 32'd0);

    // Direction and output data, upper bits and unused addresses
    bus_write(A_DIR, 32'hF0);
    bus_write(A_OUT, 32'hA5);
    check("oe_f0", 32'(gpio_oe), 32'hF0);
    check("o_a5", 32'(gpio_o), 32'hA5);
    bus_read(A_OUT, 32'hA5, "out_rb");
    bus_write(A_OUT, 32'hFFFF_FFFF);
    bus_read(A_OUT, 32'h0000_00FF, "out_upper");
    bus_write(A_OUT, 32'hA5);
    bus_write(A_R6, 32'hFFFF_FFFF);
    bus_read(A_R6, 32'd0, "reg6");
    bus_read(A_R7, 32'd0, "reg7");

    // Rising-edge capture latency and irq one cycle later
    bus_write(A_REN, 32'h0F);
    @(negedge clk);
    gpio_i = 8'h0A;
    repeat (LAT + 1) @(negedge clk);
    check("irq_early", 32'(irq), 32'd0);
    @(negedge clk);
    check("irq_set", 32'(irq), 32'd1);
    bus_read(A_PEND, 32'h0A, "pend_0a");
    bus_read(A_IN, 32'h0A, "in_0a");

    // W1C, and set winning over a same-cycle clear
    bus_write(A_PEND, 32'h02);
    bus_read(A_PEND, 32'h08, "pend_w1c");
    gpio_i = 8'h02;
    repeat (LAT + 5) @(negedge clk);
    bus_read(A_PEND, 32'h08, "pend_nofall");
    gpio_i = 8'h0A;
    repeat (LAT - 1) @(negedge clk);
    bus_write(A_PEND, 32'h08);
    bus_read(A_PEND, 32'h08, "pend_setwins");
    check("irq_held", 32'(irq), 32'd1);
    bus_write(A_PEND, 32'h08);
    bus_read(A_PEND, 32'h00, "pend_clr");
    check("irq_clr", 32'(irq), 32'd0);

    // Falling edges on all enabled pins; output pins never capture
    bus_write(A_FEN, 32'hFF);
    gpio_i = 8'hAA;
    repeat (50) @(negedge clk);
    bus_read(A_IN, 32'hAA, "in_readback");
    gpio_i = 8'h00;
    repeat (50) @(negedge clk);
    gpio_i = 8'hAA;
    repeat (50) @(negedge clk);
    gpio_i = 8'h00;
    repeat (50) @(negedge clk);
    bus_read(A_PEND, 32'h0A, "pend_inputs_only");

    // Output->input switch creates no edge; later falls on those pins do
    bus_write(A_PEND, 32'hFF);
    gpio_i = 8'hA0;
    repeat (LAT + 8) @(negedge clk);
    bus_write(A_DIR, 32'h00);
    repeat (LAT + 8) @(negedge clk);
    bus_read(A_PEND, 32'h00, "dir_switch");
    gpio_i = 8'h00;
    repeat (LAT + 8) @(negedge clk);
    bus_read(A_PEND, 32'hA0, "pend_new_inputs");

`ifdef GPIO_DEBOUNCE_EN
    // Short glitch filtered, long pulse captured
    bus_write(A_PEND, 32'hFF);
    gpio_i = 8'h01;
    repeat (5) @(negedge clk);
    gpio_i = 8'h00;
    repeat (40) @(negedge clk);
    bus_read(A_IN, 32'h00, "glitch_in");
    bus_read(A_PEND, 32'h00, "glitch_pend");
    gpio_i = 8'h01;
    repeat (20) @(negedge clk);
    gpio_i = 8'h00;
    repeat (40) @(negedge clk);
    bus_read(A_PEND, 32'h01, "pulse_pend");
`endif

    // Reset in the middle of a write request
    @(negedge clk);
    wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = 1'b1;
    wb_adr_i = A_OUT; wb_dat_i = 32'h3C;
    rst = 1'b1;
    @(negedge clk);
    check("midrst_ack", 32'(wb_ack_o), 32'd0);
    check("midrst_o", 32'(gpio_o), 32'd0);
    wb_cyc_i = 1'b0; wb_stb_i = 1'b0; wb_we_i = 1'b0;
    rst = 1'b0;
    @(negedge clk);
    bus_read(A_OUT, 32'd0, "midrst_out");
    bus_read(A_PEND, 32'd0, "midrst_pend");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
